shift_rotate_seq: RTL
=====================

// Module: shift_rotate_seq
// PURPOSE
//   Multi-cycle sequencer for the ALU shift/rotate path: SHR, SHRA, SHL, ROR, ROL executed one bit per clock.
//   Latches operand, opcode and count on start; asserts busy while stepping; pulses done when Rz is final.
//   Sits beside the combinational ALU. The control unit uses it when the single-cycle barrel path is not selected.
// PARAMETERS
//   WIDTH   32  operand/result width in bits
//   CNT_W    5  significant count bits (count taken mod 2**CNT_W); requires 2**CNT_W == WIDTH
// PORTS
//   clock    in   1      rising-edge clock
//   reset_n  in   1      asynchronous, active-low reset
//   start    in   1      request; sampled only when ready (state IDLE or DONE)
//   op       in   3      000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 illegal
//   Ra       in   WIDTH  operand
//   amount   in   32     shift/rotate count; only amount[CNT_W-1:0] used, upper bits ignored
//   Rz       out  WIDTH  working/result register; valid when done=1, held until next accepted start
//   busy     out  1      1 in RUN state
//   done     out  1      1-cycle pulse in DONE state
//   illegal  out  1      registered with the op; 1 if op was 101-111, held until next accepted start
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, Rz=0, cnt=0, op_q=0, busy=0, done=0, illegal=0. Takes effect immediately,
//     including mid-RUN; the in-flight operation is abandoned with no done pulse.
//   States: IDLE, RUN, DONE (registered; busy/done decoded from state).
//   ready = (state==IDLE) | (state==DONE). A start while in RUN is ignored (not queued).
//   Accept edge (ready & start): Rz<=Ra, op_q<=op, cnt<=amount[CNT_W-1:0], illegal<=(op>3'b100).
//     If the count is 0 or the op is illegal: next state=DONE, so Rz=Ra unchanged. Otherwise next state=RUN.
//   RUN, per edge: apply one step to Rz; cnt<=cnt-1. When cnt==1 on that edge: next state=DONE.
//     SHR : Rz <= {1'b0, Rz[W-1:1]}           SHRA: Rz <= {Rz[W-1], Rz[W-1:1]}
//     SHL : Rz <= {Rz[W-2:0], 1'b0}           ROR : Rz <= {Rz[0], Rz[W-1:1]}
//     ROL : Rz <= {Rz[W-2:0], Rz[W-1]}
//   DONE: lasts 1 cycle. With start=1: accept (back-to-back) and go to RUN or DONE per the rules above.
//     With start=0: go to IDLE.
//   Latency: done is high on the (n+1)th cycle after the accept edge (n = count mod 32). Count 0 gives 1 cycle;
//     count 31 gives 32 cycles.
//   Throughput: one operation every n+1 cycles with back-to-back starts.
//   Rz changes during RUN (intermediate values). Consumers sample only on done.
//   Rz and illegal are stable from the DONE cycle until the next accepted start.
//   Count wrap: amount=32 behaves as 0; amount=33 behaves as 1.
//   Rotating by n gives the same result as the single-cycle barrel rotator for the same count.
//   No combinational path from inputs to outputs.
// TESTING
//   1 ROR, Ra=32'h0000_0001, amount=1 -> done 2 cycles after accept, Rz=32'h8000_0000, busy high 1 cycle
//   2 SHRA Ra=32'h8000_00F0 n=4 -> Rz=32'hF800_000F, done at cycle 5; SHR same inputs -> Rz=32'h0800_000F
//   3 ROL Ra=32'h1234_5678 n=8 -> 32'h3456_7812; amount=32'h0000_0020 -> Rz=Ra, done after 1 cycle;
//     amount=31 -> 32 cycles
//   4 op=3'b111 -> illegal=1, Rz=Ra, done after 1 cycle; start during RUN ignored (result and timing unchanged)
//   5 back-to-back: start held through DONE -> second op accepted in DONE cycle, no IDLE gap, both results correct
//   6 reset_n low mid-RUN (ROR n=20, cycle 7) -> Rz=0, busy=0, no done pulse; post-reset op completes correctly;
//     random sweep vs reference model

Source files
------------

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate sequencer: one bit of SHR/SHRA/SHL/ROR/ROL per clock.
// Operand, opcode and count are latched on an accepted start; done pulses once Rz holds the final value.
module shift_rotate_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [31:0]      amount,
  output logic [WIDTH-1:0] Rz,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rz_q, rz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_s;
  logic             amount_unused_s;

  // Only the low count bits matter; the rest of amount is deliberately dropped.
  assign amount_unused_s = ^amount[31:CNT_W];

  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v, input logic [2:0] o);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = {1'b0, v[WIDTH-1:1]};
      3'b001:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b010:  r = {v[WIDTH-2:0], 1'b0};
      3'b011:  r = {v[0], v[WIDTH-1:1]};
      3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign ready_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    rz_d      = rz_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    if (ready_s && start) begin
      rz_d      = Ra;
      op_d      = op;
      cnt_d     = amount[CNT_W-1:0];
      illegal_d = (op > 3'b100);
      if ((amount[CNT_W-1:0] == CNT_ZERO) || (op > 3'b100)) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          rz_d  = step_fn(rz_q, op_q);
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rz_q      <= {WIDTH{1'b0}};
      cnt_q     <= CNT_ZERO;
      op_q      <= 3'b000;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rz_q      <= rz_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Rz      = rz_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
